qed_dup_sequencer: RTL and testbench

- Parametrised successor to the QED instruction mux.
- Sits between fetch and decode. Forwards original (QIC) instructions with zero latency and captures each instruction's QED-transformed duplicate in a small FIFO.
- After a programmable batch of originals, replays the buffered duplicates in order (EDDI-V batch scheme).
- Batch length 1 gives the classic interleaved orig/dup stream; ena=0 gives transparent passthrough.

---
 rtl/qed_pkg.sv | 13 +
 rtl/qed_dup_fifo.sv | 64 ++++++
 rtl/qed_dup_sequencer.sv | 142 ++++++++++++++
 tb/tb_qed_dup_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/qed_pkg.sv
// qed_pkg: shared types and constants for the QED duplicate sequencer.
//   qed_state_e : sequencer states (originals forwarded / duplicates replayed)
//   QED_NOP     : RISC-V NOP (addi x0,x0,0), the reset contents of FIFO entries
package qed_pkg;

  typedef enum logic [0:0] {
    QED_ORIG  = 1'b0,
    QED_DRAIN = 1'b1
  } qed_state_e;

  localparam logic [31:0] QED_NOP = 32'h0000_0013;

endpackage

// File: rtl/qed_dup_fifo.sv
// qed_dup_fifo: small synchronous FIFO holding QED-transformed duplicates.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop        : discard the head entry
//   head       : current head entry (combinational read)
//   occ        : number of stored entries (0..DEPTH)
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module qed_dup_fifo
  import qed_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] din,
  output logic [INSTR_W-1:0] head,
  output logic [CNT_W-1:0]   occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INSTR_W'(QED_NOP);
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      occ <= occ + CNT_W'(1);
      else if (pop && !push) occ <= occ - CNT_W'(1);
    end
  end

  assign head = mem[rd_ptr];

`ifndef SYNTHESIS
  // The sequencer's batch limit keeps these unreachable.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && occ == CNT_W'(DEPTH))) else $error("qed_dup_fifo: push while full");
      assert (!(pop && occ == '0)) else $error("qed_dup_fifo: pop while empty");
    end
  end
`endif

endmodule

// File: rtl/qed_dup_sequencer.sv
// qed_dup_sequencer: forwards original instructions with zero latency while
// buffering their QED duplicates, then replays each completed batch of
// duplicates in issue order (EDDI-V batch scheme).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : QED mode enable (0 = transparent passthrough)
//   batch_len           : originals per batch (0 -> 1, >DEPTH -> DEPTH)
//   flush_dup           : force replay of a partial batch
//   in_valid/in_ready   : upstream handshake
//   qic_instruction     : original instruction
//   qed_instruction     : its transformed duplicate
//   out_valid/out_ready : downstream handshake
//   instruction_out     : instruction to decode
//   exec_dup            : instruction_out is a replayed duplicate
//   orig_cnt, dup_cnt   : statistics, present only with QED_SEQ_STATS_EN
// Optional feature macro: QED_SEQ_STATS_EN.
module qed_dup_sequencer
  import qed_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [CNT_W-1:0]   batch_len,
  input  logic               flush_dup,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] qic_instruction,
  input  logic [INSTR_W-1:0] qed_instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               exec_dup
`ifdef QED_SEQ_STATS_EN
  ,
  output logic [31:0]        orig_cnt,
  output logic [31:0]        dup_cnt
`endif
);

  qed_state_e         state;
  qed_state_e         state_nxt;
  logic [CNT_W-1:0]   blen;
  logic [CNT_W-1:0]   eff_blen;
  logic [CNT_W-1:0]   occ;
  logic [INSTR_W-1:0] head;
  logic               pending;
  logic               xfer;
  logic               push;
  logic               pop;

  function automatic logic [CNT_W-1:0] norm_blen(input logic [CNT_W-1:0] b);
    if (b == '0)                return CNT_W'(1);
    else if (b > CNT_W'(DEPTH)) return CNT_W'(DEPTH);
    else                        return b;
  endfunction

  qed_dup_fifo #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (qed_instruction),
    .head  (head),
    .occ   (occ)
  );

  assign pending  = (occ != '0);
  // While the FIFO is empty the batch length tracks the port, so a batch of
  // one completes on the very transfer that latches it.
  assign eff_blen = pending ? blen : norm_blen(batch_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= QED_ORIG;
      blen  <= CNT_W'(1);
    end else begin
      state <= state_nxt;
      if (state == QED_ORIG && ena && !pending) blen <= norm_blen(batch_len);
    end
  end

  always_comb begin
    state_nxt       = state;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    instruction_out = '0;
    exec_dup        = 1'b0;
    xfer            = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    if (rst_n) begin
      case (state)
        QED_ORIG: begin
          out_valid       = in_valid;
          instruction_out = qic_instruction;
          // Leftover duplicates (flush request or QED just disabled) must be
          // replayed before any further original is accepted.
          in_ready        = out_ready & ~(pending & (~ena | flush_dup));
          xfer            = in_valid & in_ready;
          if (ena) begin
            push = xfer;
            if (pending && flush_dup)
              state_nxt = QED_DRAIN;
            else if (xfer && (occ + CNT_W'(1)) == eff_blen)
              state_nxt = QED_DRAIN;
          end else if (pending) begin
            state_nxt = QED_DRAIN;
          end
        end
        QED_DRAIN: begin
          out_valid       = 1'b1;
          instruction_out = head;
          exec_dup        = 1'b1;
          pop             = out_ready;
          if (out_ready && occ == CNT_W'(1)) state_nxt = QED_ORIG;
        end
        default: state_nxt = QED_ORIG;
      endcase
    end
  end

`ifdef QED_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_cnt <= '0;
      dup_cnt  <= '0;
    end else begin
      if (push) orig_cnt <= orig_cnt + 32'd1;
      if (pop)  dup_cnt  <= dup_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Testbench for qed_dup_sequencer: a queue-based reference model predicts the
// accepted output stream into a scoreboard; a monitor pops it on every output
// handshake. Directed scenarios are followed by randomized traffic.
module tb_qed_dup_sequencer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [CW-1:0] batch_len = '0;
  logic          flush_dup = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  qic = '0;
  logic [W-1:0]  qed = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  instruction_out;
  logic          exec_dup;
`ifdef QED_SEQ_STATS_EN
  logic [31:0]   orig_cnt;
  logic [31:0]   dup_cnt;
`endif

  qed_dup_sequencer #(.INSTR_W(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .batch_len       (batch_len),
    .flush_dup       (flush_dup),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .qic_instruction (qic),
    .qed_instruction (qed),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instruction_out (instruction_out),
    .exec_dup        (exec_dup)
`ifdef QED_SEQ_STATS_EN
    ,
    .orig_cnt        (orig_cnt),
    .dup_cnt         (dup_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] instr;
    logic         dup;
  } exp_t;

  exp_t         sb[$];     // expected accepted outputs, in order
  logic [W-1:0] dupq[$];   // model: duplicates awaiting replay
  bit           drain = 1'b0;
  int           target = 1;
  int           errors = 0;
  int           checks = 0;
  exp_t         mon_e;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h dup=%b expected nothing", instruction_out, exec_dup);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_instr", instruction_out, mon_e.instr);
        chk("sb_exec_dup", W'(exec_dup), W'(mon_e.dup));
      end
    end
  end

  // One clock cycle of stimulus; the model predicts and enqueues what decode
  // should accept, then the cycle's combinational outputs are checked.
  task automatic step(input bit e, input int bl, input bit f, input bit iv, input bit ordy,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit exp_ir, exp_ov, exp_dx, blocked;
    logic [W-1:0] exp_in;
    int pend;
    ena = e; batch_len = CW'(bl); flush_dup = f; in_valid = iv; out_ready = ordy;
    qic = a; qed = b;
    if (drain) begin
      exp_ir = 1'b0; exp_ov = 1'b1; exp_dx = 1'b1; exp_in = dupq[0];
      if (ordy) begin
        sb.push_back('{dupq[0], 1'b1});
        void'(dupq.pop_front());
        if (dupq.size() == 0) drain = 1'b0;
      end
    end else begin
      pend    = dupq.size();
      blocked = (pend != 0) && (!e || f);
      exp_ir  = ordy && !blocked;
      exp_ov  = iv; exp_dx = 1'b0; exp_in = a;
      if (iv && ordy) sb.push_back('{a, 1'b0});
      if (pend == 0) target = (bl == 0) ? 1 : ((bl > D) ? D : bl);
      if (e && iv && exp_ir) begin
        dupq.push_back(b);
        if (dupq.size() == target) drain = 1'b1;
      end
      if (blocked) drain = 1'b1;
    end
    @(negedge clk);
    chk("in_ready", W'(in_ready), W'(exp_ir));
    chk("out_valid", W'(out_valid), W'(exp_ov));
    chk("exec_dup", W'(exec_dup), W'(exp_dx));
    chk("instruction_out", instruction_out, exp_in);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), '0);
    chk("rst_exec_dup", W'(exec_dup), '0);
    chk("rst_instruction_out", instruction_out, '0);
`ifdef QED_SEQ_STATS_EN
    chk("rst_orig_cnt", orig_cnt, '0);
    chk("rst_dup_cnt", dup_cnt, '0);
`endif
  endtask

  initial begin
    // Reset with live inputs: outputs must still be forced low.
    in_valid = 1'b1; out_ready = 1'b1; qic = 32'hDEAD_BEEF; ena = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Passthrough, ena=0.
    step(0, 2, 0, 1, 1, 32'hA, 32'hA0A);
    step(0, 2, 0, 1, 1, 32'hB, 32'hB0B);
    step(0, 2, 0, 1, 1, 32'hC, 32'hC0C);

    // Interleaved orig/dup, batch 1.
    step(1, 1, 0, 1, 1, 32'h1A, 32'hF1A);
    step(1, 1, 0, 1, 1, 32'h1B, 32'hF1B);
    step(1, 1, 0, 1, 1, 32'h1B, 32'hF1B);
    step(1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Full batch of 4 with downstream back-pressure during replay.
    for (int i = 1; i <= 4; i++) step(1, 4, 0, 1, 1, 32'h40 + i, 32'h400 + i);
    for (int i = 0; i < 8; i++) step(1, 4, 0, 0, (i % 2) == 0, 32'h0, 32'h0);
    step(1, 4, 0, 1, 1, 32'h50, 32'h500);
    step(0, 4, 0, 0, 1, 32'h0, 32'h0);
    step(0, 4, 0, 0, 1, 32'h0, 32'h0);

    // Partial batch forced out by flush_dup.
    step(1, 3, 0, 1, 1, 32'h61, 32'h601);
    step(1, 3, 0, 1, 1, 32'h62, 32'h602);
    step(1, 3, 1, 0, 1, 32'h0, 32'h0);
    step(1, 3, 0, 0, 1, 32'h0, 32'h0);
    step(1, 3, 0, 0, 1, 32'h0, 32'h0);
    step(1, 3, 1, 1, 1, 32'h63, 32'h603);  // flush with empty FIFO: no effect
    step(1, 3, 0, 1, 1, 32'h64, 32'h604);
    step(1, 3, 0, 1, 1, 32'h65, 32'h605);
    for (int i = 0; i < 3; i++) step(1, 3, 0, 0, 1, 32'h0, 32'h0);

    // Clamped batch (7 -> 4) and zero batch (0 -> 1).
    for (int i = 1; i <= 4; i++) step(1, 7, 0, 1, 1, 32'h70 + i, 32'h700 + i);
    for (int i = 0; i < 4; i++) step(1, 7, 0, 0, 1, 32'h0, 32'h0);
    step(1, 0, 0, 1, 1, 32'h80, 32'h800);
    step(1, 0, 0, 0, 1, 32'h0, 32'h0);

    // Reset in the middle of a replay with two duplicates still buffered.
    for (int i = 1; i <= 4; i++) step(1, 4, 0, 1, 1, 32'h90 + i, 32'h900 + i);
    step(1, 4, 0, 0, 1, 32'h0, 32'h0);
    step(1, 4, 0, 0, 1, 32'h0, 32'h0);
    in_valid = 1'b1; out_ready = 1'b0; qic = 32'h1234_5678;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    dupq.delete(); sb.delete(); drain = 1'b0; target = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1, 0, 1, 1, 32'hAA, 32'hBB);
    step(1, 2, 0, 1, 1, 32'hAC, 32'hBC);
    step(1, 2, 0, 1, 1, 32'hAD, 32'hBD);
    step(1, 2, 0, 0, 1, 32'h0, 32'h0);
    step(1, 2, 0, 0, 1, 32'h0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom);
    end

    // Bounded drain of anything left, then the scoreboard must be empty.
    for (int i = 0; i < 20 && (drain || dupq.size() != 0); i++)
      step(0, 1, 0, 0, 1, 32'h0, 32'h0);
    @(negedge clk);
    chk("sb_leftover", W'(sb.size()), '0);
    chk("model_leftover", W'(dupq.size()), '0);
`ifdef QED_SEQ_STATS_EN
    chk("stats_balance", orig_cnt, dup_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
